power_ramp_ctrl: RTL

POWER_RAMP_CTRL -- requirements
Module: power_ramp_ctrl

---
 rtl/power_ramp_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/power_ramp_ctrl.sv
// power_ramp_ctrl: steps a thermometer enable mask over NUM_GROUPS load groups toward a
// commanded level, one group per STEP_CYCLES clocks, to bound supply di/dt.
// Optional feature: define POWER_RAMP_ABORT_EN to add the cmd_abort emergency all-off input.
module power_ramp_ctrl #(
  parameter int unsigned NUM_GROUPS  = 64,
  parameter int unsigned STEP_CYCLES = 1000,
  parameter int unsigned HB_DIV      = 50_000_000
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [7:0]            cmd_target,
`ifdef POWER_RAMP_ABORT_EN
  input  logic                  cmd_abort,
`endif
  output logic [NUM_GROUPS-1:0] grp_en,
  output logic                  ramp_busy,
  output logic [3:0]            status_led
);

  localparam int unsigned TmrW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned HbW  = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
  localparam logic [TmrW-1:0] TmrLoad  = TmrW'(STEP_CYCLES - 1);
  localparam logic [HbW-1:0]  HbLast   = HbW'(HB_DIV - 1);
  localparam logic [7:0]      LevelMax = 8'(NUM_GROUPS);

  typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

  state_e          state_q;
  logic [7:0]      level_q;
  logic [7:0]      target_q;
  logic [TmrW-1:0] tmr_q;
  logic [HbW-1:0]  hb_cnt_q;
  logic            hb_q;
  logic            lvl_nz_q;
  logic            lvl_full_q;

  logic            abort;
  logic [7:0]      cmd_clamped;
  logic [7:0]      level_step;

`ifdef POWER_RAMP_ABORT_EN
  assign abort = cmd_abort;
`else
  assign abort = 1'b0;
`endif

  // Thermometer mask: bit i set iff lvl > i.
  function automatic logic [NUM_GROUPS-1:0] therm(input logic [7:0] lvl);
    therm = '0;
    for (int i = 0; i < int'(NUM_GROUPS); i++) begin
      therm[i] = (int'(lvl) > i);
    end
  endfunction

  // Clamp the request and form the candidate next level for the current direction.
  always_comb begin
    cmd_clamped = (cmd_target > LevelMax) ? LevelMax : cmd_target;
    level_step  = (state_q == StUp) ? level_q + 8'd1 : level_q - 8'd1;
  end

  // Ramp FSM; every output is updated on the same edge as the level it reflects.
  always_ff @(posedge clk_in) begin
    if (rst || abort) begin
      state_q    <= StIdle;
      level_q    <= 8'd0;
      target_q   <= 8'd0;
      tmr_q      <= '0;
      grp_en     <= '0;
      ramp_busy  <= 1'b0;
      cmd_ready  <= 1'b1;
      lvl_nz_q   <= 1'b0;
      lvl_full_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            target_q <= cmd_clamped;
            // Equal target is accepted but leaves every output untouched.
            if (cmd_clamped != level_q) begin
              state_q   <= (cmd_clamped > level_q) ? StUp : StDown;
              tmr_q     <= TmrLoad;
              ramp_busy <= 1'b1;
              cmd_ready <= 1'b0;
            end
          end
        end
        StUp, StDown: begin
          if (tmr_q == '0) begin
            // Direction is only chosen toward a target inside 0..NUM_GROUPS, so no wrap.
            level_q    <= level_step;
            grp_en     <= therm(level_step);
            lvl_nz_q   <= (level_step != 8'd0);
            lvl_full_q <= (level_step == LevelMax);
            if (level_step == target_q) begin
              state_q   <= StIdle;
              tmr_q     <= '0;
              ramp_busy <= 1'b0;
              cmd_ready <= 1'b1;
            end else begin
              tmr_q <= TmrLoad;
            end
          end else begin
            tmr_q <= tmr_q - TmrW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Free-running heartbeat divider; abort leaves it running.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else if (hb_cnt_q == HbLast) begin
      hb_cnt_q <= '0;
      hb_q     <= ~hb_q;
    end else begin
      hb_cnt_q <= hb_cnt_q + HbW'(1);
    end
  end

  assign status_led = {lvl_nz_q, lvl_full_q, ramp_busy, hb_q};

endmodule
